// File: rtl/adc_align_training_ctrl_if.sv
// Bundle of training-control signals between the LVDS frontend and its alignment sequencer.
// The sequencer connects through the slave modport; whatever drives the frontend side uses master.
interface adc_align_training_ctrl_if #(
    parameter int LANES     = 8,
    parameter int MAX_SLIPS = 2*LANES-1
);
    localparam int SLIP_W = $clog2(MAX_SLIPS+1);

    logic                 start;
    logic                 aligned;
    logic                 word_valid;
    logic [2*LANES-1:0]   word;
    logic                 fe_rst_n;
    logic                 bitslip;
    logic                 adc_test_en;
    logic                 wr_gate;
    logic                 locked;
    logic                 fail;
    logic [SLIP_W-1:0]    slip_count;
    logic [7:0]           retrain_count;
    logic [2:0]           state_dbg;

    modport master (
        output start, aligned, word_valid, word,
        input  fe_rst_n, bitslip, adc_test_en, wr_gate, locked, fail,
               slip_count, retrain_count, state_dbg
    );

    modport slave (
        input  start, aligned, word_valid, word,
        output fe_rst_n, bitslip, adc_test_en, wr_gate, locked, fail,
               slip_count, retrain_count, state_dbg
    );
endinterface

// File: rtl/adc_align_training_ctrl.sv
// LVDS ADC alignment training sequencer (DCO domain): frontend reset, pattern check, bitslip, lock.
// Optional feature: define ALIGN_AUTO_RETRAIN_EN to retrain automatically when aligned drops in LOCKED.
module adc_align_training_ctrl #(
    parameter int                 LANES         = 8,
    parameter int                 SETTLE_CYCLES = 64,
    parameter int                 CHECK_WORDS   = 16,
    parameter int                 MAX_SLIPS     = 2*LANES-1,
    parameter logic [2*LANES-1:0] TRAIN_PATTERN = 16'hA55A
) (
    input  logic                        dco_clk,
    input  logic                        rst,
    adc_align_training_ctrl_if.slave    bus
);

    localparam int SLIP_W       = $clog2(MAX_SLIPS+1);
    localparam int CNT_W        = $clog2(SETTLE_CYCLES+1);
    localparam int MATCH_W      = $clog2(CHECK_WORDS+1);
    localparam int RESET_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RESET_FE = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_CHECK    = 3'd3,
        ST_SLIP     = 3'd4,
        ST_LOCKED   = 3'd5,
        ST_FAIL     = 3'd6
    } state_e;

    state_e               r_state;
    state_e               w_next_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     r_starve;
    logic [MATCH_W-1:0]   r_match_cnt;
    logic [SLIP_W-1:0]    r_slip_count;
    logic [7:0]           w_retrain_count;

    logic r_fe_rst_n, r_bitslip, r_adc_test_en, r_wr_gate, r_locked, r_fail;
    logic w_fe_rst_n, w_bitslip, w_adc_test_en, w_wr_gate, w_locked, w_fail;

    logic w_match, w_starved, w_mismatch, w_retrain;

    assign w_match    = bus.word_valid && bus.aligned && (bus.word == TRAIN_PATTERN);
    // A run of idle cycles as long as the settle time is treated like a bad word.
    assign w_starved  = !bus.word_valid && (r_starve == CNT_W'(SETTLE_CYCLES-1));
    assign w_mismatch = (bus.word_valid && !w_match) || w_starved;

`ifdef ALIGN_AUTO_RETRAIN_EN
    logic [7:0] r_retrain_count;

    assign w_retrain       = (r_state == ST_LOCKED) && !bus.aligned;
    assign w_retrain_count = r_retrain_count;

    always_ff @(posedge dco_clk or posedge rst) begin
        if (rst) begin
            r_retrain_count <= 8'd0;
        end else if (w_retrain && !bus.start && (r_retrain_count != 8'hFF)) begin
            r_retrain_count <= r_retrain_count + 8'd1;
        end
    end
`else
    assign w_retrain       = 1'b0;
    assign w_retrain_count = 8'd0;
`endif

    // State register plus the per-state counters that steer it.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge dco_clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_starve     <= '0;
            r_match_cnt  <= '0;
            r_slip_count <= '0;
        end else begin
            r_state <= w_next_state;

            if (bus.start || (w_next_state != r_state)) begin
                r_cnt <= '0;
            end else if ((r_state == ST_RESET_FE) || (r_state == ST_SETTLE)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if ((r_state != ST_CHECK) || bus.word_valid) begin
                r_starve <= '0;
            end else begin
                r_starve <= r_starve + 1'b1;
            end

            if (r_state != ST_CHECK) begin
                r_match_cnt <= '0;
            end else if (w_match) begin
                r_match_cnt <= r_match_cnt + 1'b1;
            end

            // Every fresh training run, manual or automatic, starts counting slips from zero.
            if ((w_next_state == ST_RESET_FE) && (bus.start || (r_state != ST_RESET_FE))) begin
                r_slip_count <= '0;
            end else if (w_next_state == ST_SLIP) begin
                r_slip_count <= r_slip_count + 1'b1;
            end
        end
    end

    // NOTE: the default assignment at the top keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     w_next_state = ST_IDLE;
            ST_RESET_FE: if (r_cnt == CNT_W'(RESET_CYCLES-1)) w_next_state = ST_SETTLE;
            ST_SETTLE:   if (r_cnt == CNT_W'(SETTLE_CYCLES-1)) w_next_state = ST_CHECK;
            ST_CHECK: begin
                if (w_match && (r_match_cnt == MATCH_W'(CHECK_WORDS-1))) begin
                    w_next_state = ST_LOCKED;
                end else if (w_mismatch) begin
                    w_next_state = (r_slip_count < SLIP_W'(MAX_SLIPS)) ? ST_SLIP : ST_FAIL;
                end
            end
            ST_SLIP:     w_next_state = ST_SETTLE;
            ST_LOCKED:   if (w_retrain) w_next_state = ST_RESET_FE;
            ST_FAIL:     w_next_state = ST_FAIL;
            default:     w_next_state = ST_IDLE;
        endcase
        if (bus.start) begin
            w_next_state = ST_RESET_FE;
        end
    end

    // Output values are decoded from the next state so the registered copies line up with r_state.
    always_comb begin
        w_fe_rst_n    = 1'b1;
        w_adc_test_en = 1'b0;
        w_bitslip     = 1'b0;
        w_locked      = 1'b0;
        w_fail        = 1'b0;
        w_wr_gate     = 1'b0;
        case (w_next_state)
            ST_IDLE:     w_fe_rst_n = 1'b0;
            ST_RESET_FE: begin
                w_fe_rst_n    = 1'b0;
                w_adc_test_en = 1'b1;
            end
            ST_SETTLE,
            ST_CHECK:    w_adc_test_en = 1'b1;
            ST_SLIP: begin
                w_adc_test_en = 1'b1;
                w_bitslip     = 1'b1;
            end
            ST_LOCKED: begin
                w_locked  = 1'b1;
                w_wr_gate = bus.aligned;
            end
            ST_FAIL:     w_fail = 1'b1;
            default:     w_fe_rst_n = 1'b0;
        endcase
    end

    always_ff @(posedge dco_clk or posedge rst) begin
        if (rst) begin
            r_fe_rst_n    <= 1'b0;
            r_bitslip     <= 1'b0;
            r_adc_test_en <= 1'b0;
            r_wr_gate     <= 1'b0;
            r_locked      <= 1'b0;
            r_fail        <= 1'b0;
        end else begin
            r_fe_rst_n    <= w_fe_rst_n;
            r_bitslip     <= w_bitslip;
            r_adc_test_en <= w_adc_test_en;
            r_wr_gate     <= w_wr_gate;
            r_locked      <= w_locked;
            r_fail        <= w_fail;
        end
    end

    assign bus.fe_rst_n      = r_fe_rst_n;
    assign bus.bitslip       = r_bitslip;
    assign bus.adc_test_en   = r_adc_test_en;
    assign bus.wr_gate       = r_wr_gate;
    assign bus.locked        = r_locked;
    assign bus.fail          = r_fail;
    assign bus.slip_count    = r_slip_count;
    assign bus.retrain_count = w_retrain_count;
    assign bus.state_dbg     = r_state;

endmodule
